key_debounce_pulse: RTL and testbench
=====================================

// Module: key_debounce_pulse
// PURPOSE
//  Upstream stage of the vending-machine control block.
//  Synchronises the raw coin push-buttons (key1 = 0.5 yuan, key2 = 1 yuan) and debounces them.
//  Emits exactly one single-cycle pulse per physical press, plus a debounced level.
//  key_pulse feeds the coin inputs of the control block directly; one press is counted as one coin.
// PARAMETERS
//  NUM_KEYS     2           number of independent keys
//  CLK_HZ       50_000_000  system clock frequency in Hz
//  DEBOUNCE_MS  20          required stable time in ms
//  DB_CYCLES    localparam  = CLK_HZ/1000*DEBOUNCE_MS; must be >= 2 (checked at elaboration)
// PORTS
//  clk        in   1         system clock, 50 MHz
//  rst        in   1         synchronous, active-high reset
//  key_in     in   NUM_KEYS  raw buttons, active-low (0 = pressed), asynchronous to clk
//  key_level  out  NUM_KEYS  debounced state, active-high (1 = pressed)
//  key_pulse  out  NUM_KEYS  1-cycle strobe on each debounced press (release->press)
// BEHAVIOUR
//  Reset (rst=1 sampled at posedge clk):
//   - sync flops = 1 (released)
//   - counters = 0
//   - key_level = 0 and key_pulse = 0 from the next cycle on
//   - an in-progress count is discarded; no pulse is generated by reset itself.
//  Per key, fully independent; all keys share only clk and rst:
//   - 2-FF synchroniser: s1 <= ~key_in[i]; s2 <= s1. s2 is the active-high sample.
//   - counter cnt, width $clog2(DB_CYCLES).
//   - if s2 == key_level[i]: cnt <= 0.
//   - else if cnt == DB_CYCLES-1: key_level[i] <= s2; cnt <= 0.
//   - else: cnt <= cnt + 1.
//   - key_pulse[i] <= (s2 & ~key_level[i] & cnt == DB_CYCLES-1). It is registered, so it goes high
//     in the same cycle key_level[i] rises, and it is low in every other cycle.
//  Latency: after a clean raw press, key_level/key_pulse rise after exactly DB_CYCLES+2 posedges
//   (2 synchroniser + DB_CYCLES counter). Release behaves the same for key_level, with no pulse.
//  Glitch rejection: any bounce that returns to the stable value before DB_CYCLES consecutive
//   differing samples resets cnt to 0. The level does not change and no pulse is produced.
//  Held key: exactly one pulse; no auto-repeat for any hold length.
//  Counter never wraps: the saturation value DB_CYCLES-1 always forces a clear.
//  Simultaneous presses on several keys yield simultaneous pulses. No arbitration is done here;
//   the control block resolves priority.
//  Reset asserted mid-count or while held: outputs go to 0. A key still held after reset release is
//   re-qualified from scratch, which gives one pulse after DB_CYCLES+2 cycles.
// STRUCTURE
//  - Shared package/header vm_defs: CLK_HZ_DEFAULT, DEBOUNCE_MS_DEFAULT, NUM_COIN_KEYS = 2.
//  - One sub-module debounce_cell: handles a single key (synchroniser + counter + level + pulse).
//    It is instantiated NUM_KEYS times in a generate loop.
//  - Top of this block holds only parameter math and the generate loop.
// TESTING  (bench uses CLK_HZ=1000, DEBOUNCE_MS=4 -> DB_CYCLES=4)
//  - Reset with key_in=2'b11 held for 10 cycles -> key_level=0 and key_pulse=0 throughout.
//  - key_in[0]=0 clean from cycle 0 -> key_pulse[0]=1 in exactly one cycle, the 6th posedge;
//    key_level[0]=1 from then on; key_pulse[1] stays 0.
//  - key_in[0] bounces 0,1,0,1 (1 cycle each), then held 0 -> single pulse, 6 posedges after the
//    last 1->0 edge.
//  - Both keys pressed on the same cycle and held 100 cycles -> key_pulse=2'b11 for one cycle only,
//    then 2'b00; release -> key_level=0 after 6 cycles, no pulse.
//  - rst pulsed while a key is held and cnt=2 -> outputs 0; after rst drops, one new pulse after
//    6 posedges.
//  - 3-cycle low glitch on key_in[1] -> key_level[1] and key_pulse[1] stay 0.

Source files
------------

// File: rtl/key_debounce_pulse_pkg.sv
// key_debounce_pulse_pkg: shared vending-machine defaults and debounce cycle math
package key_debounce_pulse_pkg;
   localparam int CLK_HZ_DEFAULT      = 50_000_000;
   localparam int DEBOUNCE_MS_DEFAULT = 20;
   localparam int NUM_COIN_KEYS       = 2;
   function automatic int db_cycles(input int clk_hz, input int debounce_ms);
      return clk_hz / 1000 * debounce_ms;
   endfunction
endpackage

// File: rtl/key_debounce_pulse_if.sv
// key_debounce_pulse_if: raw coin keys in, debounced level and press strobe out
interface key_debounce_pulse_if #(parameter int NUM_KEYS = 2);
   logic [NUM_KEYS-1:0] key_in;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_pulse;
   modport master (output key_in, input key_level, key_pulse);
   modport slave (input key_in, output key_level, key_pulse);
endinterface

// File: rtl/key_debounce_pulse_cell.sv
// key_debounce_pulse_cell: one key - synchroniser, stability counter, level and press pulse
module key_debounce_pulse_cell #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic level,
   output logic pulse
);
   localparam int CW = $clog2(DB_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
   // synchroniser keeps raw (active-low) polarity, so all-ones means released
   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          smp;
   logic          hit;
   assign smp = ~sync[1];
   assign hit = cnt == LAST;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync  <= '1;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[0], key_raw};
         cnt   <= (smp == level || hit) ? '0 : cnt + 1'b1;
         level <= (smp != level && hit) ? smp : level;
         pulse <= smp & ~level & hit;
      end
   end
endmodule

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse: debounces the coin push-buttons, one strobe per physical press
module key_debounce_pulse
   import key_debounce_pulse_pkg::*;
#(
   parameter int NUM_KEYS    = NUM_COIN_KEYS,
   parameter int CLK_HZ      = CLK_HZ_DEFAULT,
   parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEFAULT
) (
   input logic clk,
   input logic rst,
   key_debounce_pulse_if.slave bus
);
   localparam int DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_MS);
   if (DB_CYCLES < 2) begin : g_bad_cfg
      $error("key_debounce_pulse: DB_CYCLES must be at least 2");
   end
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce_pulse_cell #(.DB_CYCLES(DB_CYCLES)) u_cell (
         .clk     (clk),
         .rst     (rst),
         .key_raw (bus.key_in[i]),
         .level   (bus.key_level[i]),
         .pulse   (bus.key_pulse[i])
      );
   end
endmodule

// File: tb/tb_key_debounce_pulse.sv
// tb_key_debounce_pulse: directed and random key stimulus against a sample-history reference model
module tb_key_debounce_pulse;
   import key_debounce_pulse_pkg::*;
   localparam int NK = 2;
   localparam int DB = 4;
   logic clk = 1'b0;
   logic rst;
   int n_chk = 0;
   int n_fail = 0;
   key_debounce_pulse_if #(.NUM_KEYS(NK)) bus ();
   key_debounce_pulse #(.NUM_KEYS(NK), .CLK_HZ(1000), .DEBOUNCE_MS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   // reference: a key's level flips once DB consecutive samples since its last flip all disagree with it
   logic [NK-1:0] raw_q[$] = '{2'b11, 2'b11};
   int            chg[NK];
   logic [NK-1:0] m_lvl = '0;
   logic [NK-1:0] m_pls = '0;
   always @(posedge clk) begin
      if (rst) begin
         raw_q = '{2'b11, 2'b11};
         m_lvl = '0;
         m_pls = '0;
         for (int i = 0; i < NK; i++) chg[i] = 0;
      end else begin
         int n;
         int e;
         raw_q.push_back(bus.key_in);
         n = raw_q.size();
         e = n - 2;
         for (int i = 0; i < NK; i++) begin
            bit flip;
            m_pls[i] = 1'b0;
            flip = (e - chg[i]) >= DB;
            for (int j = 0; j < DB && flip; j++)
               if (~raw_q[n-3-j][i] == m_lvl[i]) flip = 0;
            if (flip) begin
               m_lvl[i] = ~m_lvl[i];
               m_pls[i] = m_lvl[i];
               chg[i]   = e;
            end
         end
      end
   end
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   int tk;
   int pc[NK];
   int pt[NK];
   task automatic clr();
      tk = 0;
      for (int i = 0; i < NK; i++) begin
         pc[i] = 0;
         pt[i] = 0;
      end
   endtask
   task automatic tick();
      @(negedge clk);
      tk++;
      check("level", int'(bus.key_level), int'(m_lvl));
      check("pulse", int'(bus.key_pulse), int'(m_pls));
      for (int i = 0; i < NK; i++)
         if (bus.key_pulse[i]) begin
            pc[i]++;
            if (pt[i] == 0) pt[i] = tk;
         end
   endtask
   task automatic ticks(input int n);
      repeat (n) tick();
   endtask
   int rem[NK];
   initial begin
      rst = 1'b1;
      bus.key_in = 2'b11;
      clr();
      repeat (10) begin
         tick();
         check("rst_level", int'(bus.key_level), 0);
         check("rst_pulse", int'(bus.key_pulse), 0);
      end
      rst = 1'b0;
      bus.key_in = 2'b10;
      clr();
      ticks(12);
      check("clean_pulse_time", pt[0], 6);
      check("clean_pulse_count", pc[0], 1);
      check("clean_other_key", pc[1], 0);
      check("clean_level", int'(bus.key_level), 1);
      bus.key_in = 2'b11;
      ticks(10);
      foreach (rem[i]) rem[i] = 0;
      bus.key_in = 2'b10; tick();
      bus.key_in = 2'b11; tick();
      bus.key_in = 2'b10; tick();
      bus.key_in = 2'b11; tick();
      bus.key_in = 2'b10;
      clr();
      ticks(12);
      check("bounce_pulse_time", pt[0], 6);
      check("bounce_pulse_count", pc[0], 1);
      bus.key_in = 2'b11;
      ticks(10);
      bus.key_in = 2'b00;
      clr();
      ticks(100);
      check("both_pulse_count0", pc[0], 1);
      check("both_pulse_count1", pc[1], 1);
      check("both_pulse_time0", pt[0], 6);
      check("both_pulse_time1", pt[1], 6);
      bus.key_in = 2'b11;
      clr();
      ticks(5);
      check("release_level_held", int'(bus.key_level), 3);
      tick();
      check("release_level", int'(bus.key_level), 0);
      check("release_no_pulse", pc[0] + pc[1], 0);
      ticks(4);
      bus.key_in = 2'b10;
      ticks(4);
      rst = 1'b1;
      tick();
      check("midcount_rst_level", int'(bus.key_level), 0);
      rst = 1'b0;
      clr();
      ticks(12);
      check("requal_pulse_time", pt[0], 6);
      check("requal_pulse_count", pc[0], 1);
      bus.key_in = 2'b11;
      ticks(10);
      bus.key_in = 2'b01;
      clr();
      ticks(3);
      bus.key_in = 2'b11;
      ticks(10);
      check("glitch_pulse_count", pc[1], 0);
      check("glitch_level", int'(bus.key_level[1]), 0);
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NK; i++) begin
            if (rem[i] == 0) begin
               bus.key_in[i] = ~bus.key_in[i];
               rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 14) : $urandom_range(1, 3);
            end
            rem[i]--;
         end
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
